// File: rtl/hex_scroll_ctrl_if.sv
// Byte-load, control and shared-decoder signals of the scrolling HEX sequencer.
// The slave modport is the sequencer; master is whoever loads it and hosts the decoder.
interface hex_scroll_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    wr_valid;
  logic [7:0]              wr_char;
  logic                    wr_ready;
  logic                    commit;
  logic                    clear;
  logic [7:0]              dec_ascii;
  logic [6:0]              dec_seg;
  logic [7*NUM_DIGITS-1:0] hex;
  logic                    busy;

  modport master (
    output wr_valid, wr_char, commit, clear, dec_seg,
    input  wr_ready, dec_ascii, hex, busy
  );

  modport slave (
    input  wr_valid, wr_char, commit, clear, dec_seg,
    output wr_ready, dec_ascii, hex, busy
  );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scrolling-message sequencer: buffers ASCII characters, then time-multiplexes one
// shared 7-segment decoder across the HEX digits while stepping a scroll offset.
module hex_scroll_ctrl #(
  parameter int MSG_DEPTH  = 16,
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 25_000_000
) (
  input logic              clk,
  input logic              rst_n,
  hex_scroll_ctrl_if.slave bus
);
  localparam int VLEN_MAX = MSG_DEPTH + NUM_DIGITS;
  localparam int CW = $clog2(MSG_DEPTH + 1);
  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int OW = $clog2(VLEN_MAX);
  localparam int SW = $clog2(2 * VLEN_MAX);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DEPTH     = CW'(MSG_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] SCAN_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] DIGITS_SW = SW'(NUM_DIGITS);
  localparam logic [SW-1:0] POS_LAST  = SW'(NUM_DIGITS - 1);
  localparam logic [7:0]    BLANK     = 8'h20;

  typedef enum logic {LOAD, SCROLL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [OW-1:0] offset;
  logic [TW-1:0] tick;
  logic [DW-1:0] scan;
  logic [7:0]    msg_buf [MSG_DEPTH];
  logic [6:0]    hex_q   [NUM_DIGITS];

  logic          wr_fire, wr_ready, busy;
  logic [7:0]    dec_ascii, scroll_char;
  logic [SW-1:0] vlen, pos, vsum, vidx;

  assign wr_fire   = rst_n & bus.wr_valid & wr_ready & ~bus.clear;
  assign count_nxt = count + {{(CW-1){1'b0}}, wr_fire};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next state: the commit test sees count including a same-cycle write.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (!bus.clear && bus.commit && count_nxt != '0) state_nxt = SCROLL;
      SCROLL:  if (bus.clear) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs; in LOAD the decoder is fed blanks so every digit decodes dark.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ready  = 1'b0;
    busy      = 1'b0;
    dec_ascii = BLANK;
    case (state)
      LOAD:    wr_ready = (count < DEPTH);
      SCROLL:  begin
        busy      = 1'b1;
        dec_ascii = scroll_char;
      end
      default: ;
    endcase
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.busy      = busy;
  assign bus.dec_ascii = dec_ascii;

  // Character for the digit under scan: position 0 is the leftmost digit.
  // offset+pos is always below 2L, so one conditional subtract replaces the modulo.
  always_comb begin
    vlen        = SW'(count) + DIGITS_SW;
    pos         = POS_LAST - SW'(scan);
    vsum        = SW'(offset) + pos;
    vidx        = (vsum >= vlen) ? vsum - vlen : vsum;
    scroll_char = BLANK;
    if (vidx < SW'(count)) scroll_char = msg_buf[vidx[AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      offset <= '0;
      tick   <= '0;
      scan   <= '0;
    end else begin
      scan  <= (scan == SCAN_LAST) ? '0 : scan + DW'(1);
      count <= bus.clear ? '0 : count_nxt;
      if (state == SCROLL && !bus.clear) begin
        if (tick == TICK_LAST) begin
          tick   <= '0;
          offset <= (SW'(offset) == vlen - SW'(1)) ? '0 : offset + OW'(1);
        end else begin
          tick <= tick + TW'(1);
        end
      end else begin
        tick   <= '0;
        offset <= '0;
      end
    end
  end

  // NOTE: the message buffer is deliberately not reset; count alone marks valid entries.
  always_ff @(posedge clk) begin
    if (wr_fire) msg_buf[count[AW-1:0]] <= bus.wr_char;
  end

  // Digit registers: refreshed one per cycle, blanked all at once by reset or clear.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) hex_q[k] <= 7'h7F;
    end else begin
      hex_q[scan] <= bus.dec_seg;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_hex
    assign bus.hex[7*k +: 7] = hex_q[k];
  end
endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a message-level model of the scrolling display.
module tb_hex_scroll_ctrl;
  localparam int MSG_DEPTH  = 4;
  localparam int NUM_DIGITS = 6;
  localparam int TICK_DIV   = 4;
  localparam logic [7*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{7'h7F}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hex_scroll_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  hex_scroll_ctrl #(
    .MSG_DEPTH (MSG_DEPTH),
    .NUM_DIGITS(NUM_DIGITS),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Shared decoder (active-low segments).
  function automatic logic [6:0] seg_of(input logic [7:0] a);
    case (a)
      8'h20:   return 7'h7F;
      "H":     return 7'b0001011;
      "I":     return 7'b1001111;
      "A":     return 7'b0001000;
      "0":     return 7'b1000000;
      "B":     return 7'b0000011;
      default: return a[6:0] ^ 7'h2A;
    endcase
  endfunction

  assign bus.dec_seg = seg_of(bus.dec_ascii);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: message as a queue, elapsed scroll cycles, digit images.
  logic [7:0] msg_q [$];
  bit         m_scroll;
  int         m_sc;
  int         m_scan;
  logic [6:0] m_hex [NUM_DIGITS];

  function automatic int m_offset();
    return (m_sc / TICK_DIV) % (msg_q.size() + NUM_DIGITS);
  endfunction

  function automatic logic [7:0] m_char(input int p);
    int l = msg_q.size() + NUM_DIGITS;
    int v = (m_offset() + p) % l;
    if (v < msg_q.size()) return msg_q[v];
    return 8'h20;
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] m_image();
    logic [7*NUM_DIGITS-1:0] v;
    for (int k = 0; k < NUM_DIGITS; k++) v[7*k +: 7] = m_hex[k];
    return v;
  endfunction

  function automatic logic [6:0] digit(input int k);
    logic [7*NUM_DIGITS-1:0] h = bus.hex;
    return h[7*k +: 7];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      msg_q.delete();
      m_scroll = 0;
      m_sc     = 0;
      m_scan   = 0;
      for (int k = 0; k < NUM_DIGITS; k++) m_hex[k] = 7'h7F;
      return;
    end
    if (bus.clear) for (int k = 0; k < NUM_DIGITS; k++) m_hex[k] = 7'h7F;
    else m_hex[m_scan] = m_scroll ? seg_of(m_char(NUM_DIGITS - 1 - m_scan)) : 7'h7F;
    m_scan = (m_scan + 1) % NUM_DIGITS;
    if (bus.clear) begin
      msg_q.delete();
      m_scroll = 0;
      m_sc     = 0;
    end else if (!m_scroll) begin
      if (bus.wr_valid && msg_q.size() < MSG_DEPTH) msg_q.push_back(bus.wr_char);
      if (bus.commit && msg_q.size() > 0) begin
        m_scroll = 1;
        m_sc     = 0;
      end
    end else begin
      m_sc++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("hex",       bus.hex,       m_image());
    check("busy",      bus.busy,      m_scroll);
    check("wr_ready",  bus.wr_ready,  !m_scroll && msg_q.size() < MSG_DEPTH);
    check("dec_ascii", bus.dec_ascii, m_scroll ? m_char(NUM_DIGITS - 1 - m_scan) : 8'h20);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_idle();
    bus.wr_valid = 1'b0;
    bus.wr_char  = 8'($urandom);
    bus.commit   = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic write_char(input logic [7:0] c);
    bus.wr_valid = 1'b1;
    bus.wr_char  = c;
    cycle();
    set_idle();
  endtask

  // Idle until the next commit edge samples scan == 3, so digits 4 and 5 are
  // refreshed on the 1st and 2nd edges after entering SCROLL.
  task automatic align_scan();
    for (int i = 0; i < NUM_DIGITS && m_scan != 3; i++) cycle();
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    cycle();
    bus.commit = 1'b0;
  endtask

  logic [7:0] pool [5] = '{"H", "I", "A", "0", "B"};

  initial begin
    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'($urandom);
      bus.wr_char  = 8'($urandom);
      bus.commit   = 1'($urandom);
      bus.clear    = 1'($urandom);
      cycle();
    end
    check("rst_hex",       bus.hex,       ALL_BLANK);
    check("rst_wr_ready",  bus.wr_ready,  1'b1);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_dec_ascii", bus.dec_ascii, 8'h20);
    rst_n = 1'b1;
    set_idle();
    cycle();

    // "HI" scrolled across the display.
    write_char("H");
    write_char("I");
    align_scan();
    pulse_commit();
    check("hi_busy", bus.busy, 1'b1);
    run(6);
    check("hi_d5", digit(5), 7'b0001011);
    check("hi_d4", digit(4), 7'b1001111);
    check("hi_d3_0", bus.hex[27:0], {4{7'h7F}});
    run(2);
    check("step1_d5", digit(5), 7'b1001111);
    check("step1_d4", digit(4), 7'h7F);
    run(7);
    check("step3_d0", digit(0), 7'b0001011);
    run(21);
    check("wrap_d3_0", bus.hex[27:0], {4{7'h7F}});
    run(32);
    check("wrap_d5", digit(5), 7'b0001011);
    check("wrap_d4", digit(4), 7'b1001111);

    // Fill buffer, overflow offer, commit.
    bus.clear = 1'b1;
    cycle();
    set_idle();
    write_char("A");
    write_char("0");
    write_char("A");
    write_char("B");
    check("full_wr_ready", bus.wr_ready, 1'b0);
    write_char("X");
    check("full_wr_ready2", bus.wr_ready, 1'b0);
    align_scan();
    pulse_commit();
    run(4);
    check("full_d5", digit(5), 7'b0001000);
    check("full_d4", digit(4), 7'b1000000);
    check("full_d1", digit(1), 7'h7F);
    check("full_d0", digit(0), 7'h7F);
    run(10);

    // clear together with commit and a write while scrolling.
    bus.clear    = 1'b1;
    bus.commit   = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_char  = "Z";
    cycle();
    set_idle();
    check("clr_busy",     bus.busy,     1'b0);
    check("clr_hex",      bus.hex,      ALL_BLANK);
    check("clr_wr_ready", bus.wr_ready, 1'b1);
    pulse_commit();
    check("empty_commit_busy", bus.busy, 1'b0);

    // Write and commit in the same cycle with an empty buffer.
    bus.wr_valid = 1'b1;
    bus.wr_char  = "A";
    bus.commit   = 1'b1;
    cycle();
    set_idle();
    check("same_cycle_busy", bus.busy, 1'b1);
    run(12);

    // Reset mid-scroll.
    rst_n        = 1'b0;
    bus.commit   = 1'b1;
    bus.wr_valid = 1'b1;
    cycle();
    rst_n = 1'b1;
    set_idle();
    check("rst2_busy",     bus.busy,     1'b0);
    check("rst2_hex",      bus.hex,      ALL_BLANK);
    check("rst2_wr_ready", bus.wr_ready, 1'b1);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      bus.clear    = ($urandom_range(0, 63) == 0);
      bus.commit   = ($urandom_range(0, 15) == 0);
      bus.wr_valid = 1'($urandom);
      bus.wr_char  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 4)];
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
